spart_io_arbiter: RTL and testbench

- Shares the single SPART processor-side IO bus (iocs/iorw/ioaddr/bidirectional databus) between two independent bus masters, e.g. the console driver and a second traffic source.
- Arbitrates round-robin and runs one fixed-length bus transaction per grant.
- Gates buffer accesses on SPART status: TX writes wait for tbr, RX reads wait for rda.
- Sits between the masters and the SPART; the only block that drives the SPART-side bus.

---
 rtl/spart_io_arbiter.sv | 138 +++++++++++++
 tb/tb_spart_io_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spart_io_arbiter.sv
// spart_io_arbiter
// Lets two independent bus masters share the processor-side IO bus of one
// SPART. Requests are arbitrated round-robin. Each grant runs one fixed
// three-cycle transaction: IDLE (select and latch) -> ACCESS (chip select
// asserted) -> DONE (completion pulse). Data-buffer accesses can be held
// back until the SPART is ready: TX writes wait for tbr, RX reads wait for rda.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   req0/1, rw0/1         request per master; rw = 1 means read
//   addr0/1, wdata0/1     SPART register address and write data per master
//   gnt0/1                master owns the bus (ACCESS and DONE cycles)
//   done0/1               one-cycle completion pulse
//   rdata                 last read data; held until the next read completes
//   rda, tbr              SPART status: receive data available, transmit ready
//   iocs, iorw, ioaddr    SPART-side bus control
//   databus               SPART data bus; driven only during a write ACCESS
module spart_io_arbiter #(
    parameter bit GATE_EN    = 1'b1,
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;       // requester owning the current transaction
    logic        prio_q, prio_d;     // requester that wins a tie
    logic        rw_q, rw_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        elig0, elig1;
    logic        busy;
    logic        drive_en;

    // Only the data-buffer register depends on SPART status; the direction
    // picks which status bit matters.
    always_comb begin
        elig0 = req0;
        elig1 = req1;
        if (GATE_EN) begin
            if (addr0 == 2'b00) elig0 = req0 && (rw0 ? rda : tbr);
            if (addr1 == 2'b00) elig1 = req1 && (rw1 ? rda : tbr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            prio_q  <= PRIO_RESET;
            rw_q    <= 1'b0;
            addr_q  <= 2'b00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (elig0 || elig1) begin
                    // Tie goes to the pointer; otherwise the single eligible one.
                    sel_d   = (elig0 && elig1) ? prio_q : elig1;
                    rw_d    = sel_d ? rw1    : rw0;
                    addr_d  = sel_d ? addr1  : addr0;
                    wdata_d = sel_d ? wdata1 : wdata0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (rw_q) rdata_d = databus;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                prio_d  = ~sel_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset releases the bus and drops grants immediately.
    assign busy     = (state_q == ST_ACCESS) || (state_q == ST_DONE);
    assign gnt0     = busy && !sel_q;
    assign gnt1     = busy &&  sel_q;
    assign done0    = (state_q == ST_DONE) && !sel_q;
    assign done1    = (state_q == ST_DONE) &&  sel_q;
    assign iocs     = (state_q == ST_ACCESS);
    assign iorw     = iocs && rw_q;
    assign ioaddr   = iocs ? addr_q : 2'b00;
    assign drive_en = iocs && !rw_q;
    assign databus  = drive_en ? wdata_q : 8'bzzzz_zzzz;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_spart_io_arbiter.sv
module tb_spart_io_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 0, req1 = 0, rw0 = 0, rw1 = 0;
    logic [1:0] addr0 = 0, addr1 = 0;
    logic [7:0] wdata0 = 0, wdata1 = 0;
    logic       rda = 0, tbr = 0;
    logic       gnt0, gnt1, done0, done1, iocs, iorw;
    logic [1:0] ioaddr;
    logic [7:0] rdata;
    wire  [7:0] databus;
    logic [7:0] tb_bus = 8'h3C;

    // Second instance with status gating disabled; shares all inputs.
    logic       gnt0_b, gnt1_b, done0_b, done1_b, iocs_b, iorw_b;
    logic [1:0] ioaddr_b;
    logic [7:0] rdata_b;
    wire  [7:0] databus_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // SPART model: drives the bus whenever the arbiter is not writing.
    assign databus   = (iocs && !iorw)     ? 8'bzzzz_zzzz : tb_bus;
    assign databus_b = (iocs_b && !iorw_b) ? 8'bzzzz_zzzz : tb_bus;

    spart_io_arbiter #(.GATE_EN(1'b1), .PRIO_RESET(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .rda(rda), .tbr(tbr),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus)
    );

    spart_io_arbiter #(.GATE_EN(1'b0), .PRIO_RESET(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
        .rdata(rdata_b), .rda(rda), .tbr(tbr),
        .iocs(iocs_b), .iorw(iorw_b), .ioaddr(ioaddr_b), .databus(databus_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_gnt",   {6'd0, gnt1, gnt0}, 8'h00);
        chk("rst_done",  {6'd0, done1, done0}, 8'h00);
        chk("rst_iocs",  {6'd0, iorw, iocs}, 8'h00);
        chk("rst_ioaddr", {6'd0, ioaddr}, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_bus",   databus, tb_bus);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: master 0 writes 0x45 to divisor low
        req0 = 1; rw0 = 0; addr0 = 2'b10; wdata0 = 8'h45;
        tick();
        chk("t1_iocs",   {7'd0, iocs}, 8'h01);
        chk("t1_iorw",   {7'd0, iorw}, 8'h00);
        chk("t1_ioaddr", {6'd0, ioaddr}, 8'h02);
        chk("t1_bus",    databus, 8'h45);
        chk("t1_gnt",    {6'd0, gnt1, gnt0}, 8'h01);
        tick();
        chk("t1_done",   {6'd0, done1, done0}, 8'h01);
        chk("t1_iocs_off", {7'd0, iocs}, 8'h00);
        chk("t1_bus_rel", databus, tb_bus);
        req0 = 0;
        tick();
        chk("t1_idle",   {4'd0, done1, done0, gnt1, gnt0}, 8'h00);

        // 2: master 1 reads data buffer; held off while rda is low
        tb_bus = 8'hA5;
        req1 = 1; rw1 = 1; addr1 = 2'b00; rda = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_wait_iocs", {7'd0, iocs}, 8'h00);
        end
        rda = 1;
        tick();
        chk("t2_iocs",   {6'd0, iorw, iocs}, 8'h03);
        chk("t2_ioaddr", {6'd0, ioaddr}, 8'h00);
        chk("t2_gnt",    {6'd0, gnt1, gnt0}, 8'h02);
        tick();
        chk("t2_done",   {6'd0, done1, done0}, 8'h02);
        chk("t2_rdata",  rdata, 8'hA5);
        req1 = 0; rda = 0;
        tb_bus = 8'h5A;
        tick();
        chk("t2_rdata_hold", rdata, 8'hA5);

        // 3: both masters read status continuously; grants alternate 0,1,0,1
        req0 = 1; rw0 = 1; addr0 = 2'b01;
        req1 = 1; rw1 = 1; addr1 = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_iocs", {7'd0, iocs}, 8'h01);
            chk("t3_gnt",  {6'd0, gnt1, gnt0}, (k % 2 == 0) ? 8'h01 : 8'h02);
            tick();
            chk("t3_done", {6'd0, done1, done0}, (k % 2 == 0) ? 8'h01 : 8'h02);
            chk("t3_iocs_gap", {7'd0, iocs}, 8'h00);
            if (k == 3) begin
                req0 = 0; req1 = 0;
            end
            tick();
            chk("t3_idle_iocs", {7'd0, iocs}, 8'h00);
        end

        // 4: master 0 TX write blocked by tbr; master 1 status read served first
        tbr = 0;
        req0 = 1; rw0 = 0; addr0 = 2'b00; wdata0 = 8'h77;
        req1 = 1; rw1 = 1; addr1 = 2'b01;
        tick();
        chk("t4_gnt1", {6'd0, gnt1, gnt0}, 8'h02);
        tick();
        chk("t4_done1", {6'd0, done1, done0}, 8'h02);
        req1 = 0;
        tick();
        tick();
        chk("t4_blocked", {7'd0, iocs}, 8'h00);
        tick();
        chk("t4_blocked2", {6'd0, gnt1, gnt0}, 8'h00);
        tbr = 1;
        tick();
        chk("t4_gnt0", {6'd0, gnt1, gnt0}, 8'h01);
        chk("t4_bus",  databus, 8'h77);
        tick();
        chk("t4_done0", {6'd0, done1, done0}, 8'h01);
        req0 = 0;
        tick();

        // 5: reset in the middle of a write ACCESS
        tbr = 0;
        req0 = 1; rw0 = 0; addr0 = 2'b11; wdata0 = 8'h99;
        tick();
        chk("t5_access", {7'd0, iocs}, 8'h01);
        chk("t5_bus",    databus, 8'h99);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_iocs", {7'd0, iocs}, 8'h00);
        chk("t5_rst_gnt",  {6'd0, gnt1, gnt0}, 8'h00);
        chk("t5_rst_bus",  databus, tb_bus);
        req0 = 0;
        tick();
        chk("t5_no_done",  {6'd0, done1, done0}, 8'h00);
        rst_n = 1'b1;
        tick();
        // Pointer back at PRIO_RESET: master 0 wins a tie
        req0 = 1; rw0 = 1; addr0 = 2'b01;
        req1 = 1; rw1 = 1; addr1 = 2'b01;
        tick();
        chk("t5_prio", {6'd0, gnt1, gnt0}, 8'h01);
        tick();
        req0 = 0; req1 = 0;
        tick();

        // 6: gating disabled issues a TX write even with tbr low
        tbr = 0;
        req0 = 1; rw0 = 0; addr0 = 2'b00; wdata0 = 8'h5E;
        tick();
        chk("t6_gated_iocs",   {7'd0, iocs}, 8'h00);
        chk("t6_ungated_iocs", {7'd0, iocs_b}, 8'h01);
        chk("t6_ungated_bus",  databus_b, 8'h5E);
        tick();
        chk("t6_ungated_done", {6'd0, done1_b, done0_b}, 8'h01);
        req0 = 0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
